stb_sampler: RTL and testbench
==============================

STB_SAMPLER -- requirements
Module: stb_sampler

Interface
REQ-001 Parameter T_CNT_WIDTH, default 32: width of the strobe period input.
REQ-002 Parameter N_WIDTH, default 16: width of the sample-count request, hits_o and total_o.
REQ-003 Parameter TO_SLACK, default 8: extra cycles added to the timeout limit.
REQ-004 clk_i  in  1  single clock; all logic on its rising edge.
REQ-005 arst_ni  in  1  asynchronous, active-low reset.
REQ-006 stb_i  in  1  strobe from the upstream strobe generator, synchronous to clk_i.
REQ-007 stb_rdy_i  in  1  upstream period measured, strobes valid.
REQ-008 stb_err_i  in  1  upstream error flag.
REQ-009 stb_period_i  in  T_CNT_WIDTH  measured strobe period in clk_i cycles.
REQ-010 cmp_i  in  1  asynchronous comparator output to be sampled.
REQ-011 start_i  in  1  single-cycle request to start a measurement.
REQ-012 n_samples_i  in  N_WIDTH  number of strobes to sample; captured on start.
REQ-013 busy_o  out  1  measurement in progress.
REQ-014 valid_o  out  1  result available.
REQ-015 ready_i  in  1  consumer accepts the result.
REQ-016 hits_o  out  N_WIDTH  count of samples equal to 1.
REQ-017 total_o  out  N_WIDTH  count of samples taken.
REQ-018 err_o  out  1  measurement aborted by stb_err_i.
REQ-019 timeout_o  out  1  measurement aborted by the strobe watchdog.

Function
REQ-020 cmp_i passes through a 2-stage synchronizer to give cmp_s; stb_i is registered to give stb_q.
REQ-021 A strobe event occurs in a cycle where stb_i=1 and stb_q=0.
REQ-022 FSM states: IDLE, WAIT_RDY, SAMPLE, DONE.
REQ-023 IDLE: start_i=1 captures n_samples_i into n_req, clears hits, total, err_o and timeout_o, then goes to WAIT_RDY.
REQ-024 WAIT_RDY: stb_rdy_i=1 goes to SAMPLE, except n_req=0, which goes straight to DONE with hits=total=0.
REQ-025 SAMPLE: each strobe event increments total by 1 and increments hits by cmp_s of that same cycle.
REQ-026 SAMPLE: the strobe event that makes total equal n_req goes to DONE on the next edge; no further samples are taken.
REQ-027 SAMPLE or WAIT_RDY: stb_err_i=1 sets err_o=1 and goes to DONE, keeping the partial counts.
REQ-028 stb_err_i takes priority over a strobe event in the same cycle; that strobe is not counted.
REQ-029 DONE: valid_o=1 and goes to IDLE in the cycle ready_i=1; outputs hold until then.
REQ-030 hits_o, total_o, err_o and timeout_o are stable whenever valid_o=1 and hold their values after acceptance until the next start.
REQ-031 start_i outside IDLE is ignored, with no effect on the measurement in progress.
REQ-032 busy_o=1 in WAIT_RDY and SAMPLE, 0 otherwise.
REQ-033 The valid-to-IDLE handshake takes one cycle; start_i may be asserted in the cycle after acceptance.
REQ-034 Latency: valid_o rises 1 cycle after the final strobe event.
REQ-035 Invariant: hits_o <= total_o <= n_req, so no counter overflow is possible.

Reset
REQ-036 While arst_ni=0, regardless of state: state=IDLE, busy_o=0, valid_o=0, hits_o=0, total_o=0, err_o=0, timeout_o=0.
REQ-037 While arst_ni=0: synchronizer stages, stb_q and the watchdog are cleared to 0.
REQ-038 A reset mid-measurement discards the measurement; no result is produced.
REQ-039 Reset release is synchronized to clk_i.

Configuration
REQ-040 Macro STB_SAMPLER_TIMEOUT_EN: when defined, a T_CNT_WIDTH+1-bit watchdog runs in SAMPLE.
REQ-041 With the macro, the watchdog clears on entry to SAMPLE and on every strobe event.
REQ-042 With the macro, reaching 2*stb_period_i+TO_SLACK sets timeout_o=1 and goes to DONE with the partial counts.
REQ-043 With the macro, the limit is computed at full width, so no wrap-around occurs.
REQ-044 Without the macro, no watchdog is built, timeout_o is tied to 0, and SAMPLE waits indefinitely.

Verification
REQ-045 Scenario 1: start with n=4, stb_rdy_i=1, period 20, cmp_i high on strobes 1 and 3 -> hits_o=2, total_o=4, valid_o 1 cycle after strobe 4.
REQ-046 Scenario 2: start with n=0 -> valid_o with hits=total=0 and no strobe needed.
REQ-047 Scenario 3: stb_err_i in the same cycle as strobe 3 of 5 -> err_o=1, total_o=2.
REQ-048 Scenario 4 (macro defined): period 10, strobes stop after 1 of 3 -> timeout_o=1, total_o=1, asserted 28 cycles after the last strobe.
REQ-049 Scenario 5: ready_i held 0 for 10 cycles -> outputs stable; a second start_i during DONE is ignored.
REQ-050 Scenario 6: arst_ni low mid-SAMPLE -> all outputs 0, state IDLE, and a new start completes normally.

Source files
------------

// File: rtl/stb_sampler.sv
// Strobe-driven comparator sampler: counts strobes and comparator hits until a requested count is reached.
// Optional strobe watchdog is built when STB_SAMPLER_TIMEOUT_EN is defined.
module stb_sampler #(
  parameter int T_CNT_WIDTH = 32,
  parameter int N_WIDTH     = 16,
  parameter int TO_SLACK    = 8
) (
  input  logic                   clk_i,
  input  logic                   arst_ni,
  input  logic                   stb_i,
  input  logic                   stb_rdy_i,
  input  logic                   stb_err_i,
  input  logic [T_CNT_WIDTH-1:0] stb_period_i,
  input  logic                   cmp_i,
  input  logic                   start_i,
  input  logic [N_WIDTH-1:0]     n_samples_i,
  output logic                   busy_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [N_WIDTH-1:0]     hits_o,
  output logic [N_WIDTH-1:0]     total_o,
  output logic                   err_o,
  output logic                   timeout_o
);

  typedef enum logic [1:0] {IDLE, WAIT_RDY, SAMPLE, DONE} state_t;

  state_t               state;
  logic [1:0]           rst_sync;
  logic                 rst_n;
  logic                 cmp_meta;
  logic                 cmp_s;
  logic                 stb_q;
  logic                 stb_event;
  logic                 timeout_hit;
  logic [N_WIDTH-1:0]   n_req;
  logic [N_WIDTH-1:0]   total_inc;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cmp_meta <= 1'b0;
      cmp_s    <= 1'b0;
      stb_q    <= 1'b0;
    end else begin
      cmp_meta <= cmp_i;
      cmp_s    <= cmp_meta;
      stb_q    <= stb_i;
    end
  end

  assign stb_event = stb_i & ~stb_q;
  assign total_inc = total_o + N_WIDTH'(1);

`ifdef STB_SAMPLER_TIMEOUT_EN
  logic [T_CNT_WIDTH:0]   wdog;
  logic [T_CNT_WIDTH+1:0] wdog_limit;
  logic [T_CNT_WIDTH+1:0] wdog_next;
  logic                   timeout_q;

  // Limit and count are compared one bit wider than the watchdog so neither can wrap.
  assign wdog_limit  = {1'b0, stb_period_i, 1'b0} + (T_CNT_WIDTH+2)'(TO_SLACK);
  assign wdog_next   = {1'b0, wdog} + (T_CNT_WIDTH+2)'(1);
  assign timeout_hit = (state == SAMPLE) && !stb_err_i && !stb_event && (wdog_next >= wdog_limit);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wdog      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == IDLE && start_i) timeout_q <= 1'b0;
      else if (timeout_hit)         timeout_q <= 1'b1;
      if (state != SAMPLE || stb_event) wdog <= '0;
      else if (wdog != '1)              wdog <= wdog + 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_period;
  localparam int unused_slack = TO_SLACK;

  assign unused_period = ^stb_period_i;
  assign timeout_hit   = 1'b0;
  assign timeout_o     = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      n_req   <= '0;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
      hits_o  <= '0;
      total_o <= '0;
      err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            n_req   <= n_samples_i;
            hits_o  <= '0;
            total_o <= '0;
            err_o   <= 1'b0;
            busy_o  <= 1'b1;
            state   <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (stb_err_i) begin
            err_o   <= 1'b1;
            busy_o  <= 1'b0;
            valid_o <= 1'b1;
            state   <= DONE;
          end else if (stb_rdy_i) begin
            if (n_req == '0) begin
              busy_o  <= 1'b0;
              valid_o <= 1'b1;
              state   <= DONE;
            end else begin
              state <= SAMPLE;
            end
          end
        end
        SAMPLE: begin
          // An upstream error wins over a coincident strobe, which is then not counted.
          if (stb_err_i) begin
            err_o   <= 1'b1;
            busy_o  <= 1'b0;
            valid_o <= 1'b1;
            state   <= DONE;
          end else if (stb_event) begin
            total_o <= total_inc;
            hits_o  <= hits_o + N_WIDTH'(cmp_s);
            if (total_inc == n_req) begin
              busy_o  <= 1'b0;
              valid_o <= 1'b1;
              state   <= DONE;
            end
          end else if (timeout_hit) begin
            busy_o  <= 1'b0;
            valid_o <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stb_sampler.sv
// Scoreboard testbench for stb_sampler; the timeout scenario follows STB_SAMPLER_TIMEOUT_EN.
module tb_stb_sampler;

  localparam int TW = 32;
  localparam int NW = 16;

  typedef struct {
    logic [NW-1:0] hits;
    logic [NW-1:0] total;
    logic          err;
    logic          tmo;
  } result_t;

  logic          clk_i = 1'b0;
  logic          arst_ni;
  logic          stb_i;
  logic          stb_rdy_i;
  logic          stb_err_i;
  logic [TW-1:0] stb_period_i;
  logic          cmp_i;
  logic          start_i;
  logic [NW-1:0] n_samples_i;
  logic          busy_o;
  logic          valid_o;
  logic          ready_i;
  logic [NW-1:0] hits_o;
  logic [NW-1:0] total_o;
  logic          err_o;
  logic          timeout_o;

  result_t exp_q[$];
  int      checks = 0;
  int      passes = 0;

  stb_sampler dut (
    .clk_i        (clk_i),
    .arst_ni      (arst_ni),
    .stb_i        (stb_i),
    .stb_rdy_i    (stb_rdy_i),
    .stb_err_i    (stb_err_i),
    .stb_period_i (stb_period_i),
    .cmp_i        (cmp_i),
    .start_i      (start_i),
    .n_samples_i  (n_samples_i),
    .busy_o       (busy_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .hits_o       (hits_o),
    .total_o      (total_o),
    .err_o        (err_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  // Reference model: what a measurement should report given the strobes actually delivered.
  function automatic result_t model(input int n, input logic [15:0] pat, input int err_at,
                                    input int sent, input logic tmo_en);
    result_t r;
    r.hits = '0; r.total = '0; r.err = 1'b0; r.tmo = 1'b0;
    for (int s = 1; s <= n && s <= sent; s++) begin
      if (s == err_at) begin
        r.err = 1'b1;
        break;
      end
      r.total = r.total + 1'b1;
      r.hits  = r.hits + NW'(pat[s-1]);
    end
    r.tmo = tmo_en && !r.err && (int'(r.total) < n);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic startMeas(input int n);
    start_i     = 1'b1;
    n_samples_i = NW'(n);
    tick();
    start_i = 1'b0;
  endtask

  task automatic applyStimulus(input int period, input logic cmp, input logic err);
    cmp_i = cmp;
    stb_i = 1'b0;
    repeat (period - 1) tick();
    stb_i     = 1'b1;
    stb_err_i = err;
    tick();
    stb_i     = 1'b0;
    stb_err_i = 1'b0;
  endtask

  task automatic waitValid(input string tag, input int budget);
    int n = 0;
    while (!valid_o && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, "_valid"}, 32'(valid_o), 32'd1);
  endtask

  task automatic checkResult(input string tag);
    result_t e;
    checkOutput({tag, "_sbq"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput({tag, "_hits"},  32'(hits_o),    32'(e.hits));
      checkOutput({tag, "_total"}, 32'(total_o),   32'(e.total));
      checkOutput({tag, "_err"},   32'(err_o),     32'(e.err));
      checkOutput({tag, "_tmo"},   32'(timeout_o), 32'(e.tmo));
    end
  endtask

  task automatic accept();
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    logic [15:0] pat;
    result_t     r5;
    int          cyc;

    arst_ni = 1'b0; stb_i = 1'b0; stb_rdy_i = 1'b1; stb_err_i = 1'b0;
    stb_period_i = 32'd20; cmp_i = 1'b0; start_i = 1'b0; n_samples_i = '0; ready_i = 1'b0;
    repeat (3) tick();
    checkOutput("rst_busy",  32'(busy_o),    32'd0);
    checkOutput("rst_valid", 32'(valid_o),   32'd0);
    checkOutput("rst_hits",  32'(hits_o),    32'd0);
    checkOutput("rst_total", 32'(total_o),   32'd0);
    checkOutput("rst_err",   32'(err_o),     32'd0);
    checkOutput("rst_tmo",   32'(timeout_o), 32'd0);
    arst_ni = 1'b1;
    repeat (3) tick();

    // Scenario 1: four strobes, hits on 1 and 3, stray start mid-measurement.
    $display("[TB] scenario 1: normal measurement");
    pat = 16'b0101;
    exp_q.push_back(model(4, pat, 0, 4, 1'b0));
    startMeas(4);
    checkOutput("s1_busy", 32'(busy_o), 32'd1);
    for (int s = 1; s <= 3; s++) begin
      applyStimulus(20, pat[s-1], 1'b0);
      if (s == 2) startMeas(1);
    end
    checkOutput("s1_pre_valid", 32'(valid_o), 32'd0);
    applyStimulus(20, pat[3], 1'b0);
    checkOutput("s1_latency", 32'(valid_o), 32'd1);
    checkOutput("s1_busy_done", 32'(busy_o), 32'd0);
    checkResult("s1");
    accept();
    checkOutput("s1_valid_drop", 32'(valid_o), 32'd0);
    checkOutput("s1_hold_hits", 32'(hits_o), 32'd2);

    // Scenario 2: zero-sample request completes without strobes.
    $display("[TB] scenario 2: zero samples");
    exp_q.push_back(model(0, 16'b0, 0, 0, 1'b0));
    startMeas(0);
    waitValid("s2", 4);
    checkResult("s2");
    accept();

    // Scenario 3: error coincident with strobe 3 of 5.
    $display("[TB] scenario 3: upstream error");
    pat = 16'b00101;
    exp_q.push_back(model(5, pat, 3, 3, 1'b0));
    startMeas(5);
    for (int s = 1; s <= 3; s++) applyStimulus(20, pat[s-1], s == 3);
    checkOutput("s3_latency", 32'(valid_o), 32'd1);
    checkResult("s3");
    accept();

    // Scenario 4: strobes stop after the first of three.
    stb_period_i = 32'd10;
`ifdef STB_SAMPLER_TIMEOUT_EN
    $display("[TB] scenario 4: watchdog timeout");
    pat = 16'b001;
    exp_q.push_back(model(3, pat, 0, 1, 1'b1));
    startMeas(3);
    applyStimulus(10, pat[0], 1'b0);
    cyc = 0;
    while (!valid_o && cyc < 60) begin
      tick();
      cyc++;
    end
    checkOutput("s4_tmo_cycles", 32'(cyc), 32'd28);
    checkResult("s4");
    accept();
`else
    $display("[TB] scenario 4: no watchdog, sampler waits");
    pat = 16'b101;
    exp_q.push_back(model(3, pat, 0, 3, 1'b0));
    startMeas(3);
    applyStimulus(10, pat[0], 1'b0);
    repeat (100) tick();
    checkOutput("s4_still_busy", 32'(busy_o), 32'd1);
    checkOutput("s4_no_tmo", 32'(timeout_o), 32'd0);
    applyStimulus(10, pat[1], 1'b0);
    applyStimulus(10, pat[2], 1'b0);
    checkOutput("s4_latency", 32'(valid_o), 32'd1);
    checkResult("s4");
    accept();
`endif
    stb_period_i = 32'd20;

    // Scenario 5: consumer stalls; start during DONE must be ignored.
    $display("[TB] scenario 5: stalled consumer");
    pat = 16'b10;
    r5 = model(2, pat, 0, 2, 1'b0);
    exp_q.push_back(r5);
    startMeas(2);
    for (int s = 1; s <= 2; s++) applyStimulus(20, pat[s-1], 1'b0);
    for (int c = 0; c < 10; c++) begin
      if (c == 4) startMeas(7);
      else tick();
      checkOutput("s5_valid_hold", 32'(valid_o), 32'd1);
      checkOutput("s5_total_hold", 32'(total_o), 32'(r5.total));
    end
    checkResult("s5");
    accept();
    tick();
    checkOutput("s5_start_ignored", 32'(busy_o), 32'd0);
    checkOutput("s5_post_hits", 32'(hits_o), 32'(r5.hits));

    // Scenario 6: reset in the middle of sampling, then a clean measurement.
    $display("[TB] scenario 6: reset mid-measurement");
    pat = 16'b11;
    startMeas(4);
    for (int s = 1; s <= 2; s++) applyStimulus(20, pat[s-1], 1'b0);
    arst_ni = 1'b0;
    #1;
    checkOutput("s6_busy",  32'(busy_o),    32'd0);
    checkOutput("s6_valid", 32'(valid_o),   32'd0);
    checkOutput("s6_hits",  32'(hits_o),    32'd0);
    checkOutput("s6_total", 32'(total_o),   32'd0);
    checkOutput("s6_err",   32'(err_o),     32'd0);
    checkOutput("s6_tmo",   32'(timeout_o), 32'd0);
    repeat (2) tick();
    arst_ni = 1'b1;
    repeat (3) tick();
    checkOutput("s6_idle", 32'(busy_o | valid_o), 32'd0);
    exp_q.push_back(model(2, pat, 0, 2, 1'b0));
    startMeas(2);
    for (int s = 1; s <= 2; s++) applyStimulus(20, pat[s-1], 1'b0);
    checkOutput("s6_latency", 32'(valid_o), 32'd1);
    checkResult("s6");
    accept();

    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
